// File: rtl/ws281x_frame_sched.sv
// Round-robin scheduler that time-shares one ws281x_ctrl/bit-encoder pair between N_CH LED strips,
// steering RAM reads and serial data to the granted strip and enforcing the latch gap.
module ws281x_frame_sched #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned BITS_PER_FRAME = 1536,
  parameter int unsigned RST_CYCLES     = 16000,
  parameter int unsigned WDOG_CYCLES    = 4096
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [N_CH-1:0]            req_in,
  input  logic                       bit_done_in,
  input  logic                       bit_code_in,
  input  logic [5:0]                 rd_addr_in,
  output logic                       ctrl_start_out,
  output logic [$clog2(N_CH)+5:0]    ram_rd_addr_out,
  output logic [N_CH-1:0]            led_out,
  output logic [$clog2(N_CH)-1:0]    grant_ch_out,
  output logic                       busy_out,
  output logic [N_CH-1:0]            done_out,
  output logic                       err_out
);

  localparam int unsigned CH_W = $clog2(N_CH);
  localparam int unsigned BC_W = $clog2(BITS_PER_FRAME);
  localparam int unsigned GC_W = $clog2(RST_CYCLES);
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES);

  typedef enum logic [1:0] {IDLE, START, RUN, GAP} state_t;

  state_t            state, state_nx;
  logic [N_CH-1:0]   pending, pending_nx;
  logic [CH_W-1:0]   rr_ptr, rr_ptr_nx;
  logic [CH_W-1:0]   grant, grant_nx;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_nx;
  logic [WD_W-1:0]   wdog, wdog_nx;
  logic [GC_W-1:0]   gap_cnt, gap_cnt_nx;
  logic              aborted, aborted_nx;
  logic              start_nx, busy_nx, err_nx;
  logic [N_CH-1:0]   done_nx;
  logic              pick_vld;
  logic [CH_W-1:0]   pick;
  int unsigned       idx;

  // First pending channel at or after rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = (32'(rr_ptr) + i) % N_CH;
      if (!pick_vld && pending[CH_W'(idx)]) begin
        pick_vld = 1'b1;
        pick     = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    rr_ptr_nx  = rr_ptr;
    grant_nx   = grant;
    bit_cnt_nx = bit_cnt;
    wdog_nx    = wdog;
    gap_cnt_nx = gap_cnt;
    aborted_nx = aborted;
    done_nx    = '0;
    err_nx     = 1'b0;

    if (state == START) pending_nx[grant] = 1'b0;
    // A new request in the same cycle as the clear keeps the channel queued.
    pending_nx = pending_nx | req_in;

    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nx = pick;
          state_nx = START;
        end
      end
      START: begin
        rr_ptr_nx  = (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);
        bit_cnt_nx = '0;
        wdog_nx    = '0;
        aborted_nx = 1'b0;
        state_nx   = RUN;
      end
      RUN: begin
        if (bit_done_in) begin
          wdog_nx = '0;
          if (bit_cnt == BC_W'(BITS_PER_FRAME - 1)) begin
            gap_cnt_nx = '0;
            state_nx   = GAP;
          end else begin
            bit_cnt_nx = bit_cnt + BC_W'(1);
          end
        end else if (wdog == WD_W'(WDOG_CYCLES - 1)) begin
          err_nx     = 1'b1;
          aborted_nx = 1'b1;
          gap_cnt_nx = '0;
          state_nx   = GAP;
        end else begin
          wdog_nx = wdog + WD_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GC_W'(RST_CYCLES - 1)) begin
          done_nx[grant] = !aborted;
          state_nx       = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + GC_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    start_nx = (state_nx == START);
    busy_nx  = (state_nx != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      pending        <= '0;
      rr_ptr         <= '0;
      grant          <= '0;
      bit_cnt        <= '0;
      wdog           <= '0;
      gap_cnt        <= '0;
      aborted        <= 1'b0;
      ctrl_start_out <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= '0;
      err_out        <= 1'b0;
    end else begin
      state          <= state_nx;
      pending        <= pending_nx;
      rr_ptr         <= rr_ptr_nx;
      grant          <= grant_nx;
      bit_cnt        <= bit_cnt_nx;
      wdog           <= wdog_nx;
      gap_cnt        <= gap_cnt_nx;
      aborted        <= aborted_nx;
      ctrl_start_out <= start_nx;
      busy_out       <= busy_nx;
      done_out       <= done_nx;
      err_out        <= err_nx;
    end
  end

  assign grant_ch_out    = grant;
  assign ram_rd_addr_out = {grant, rd_addr_in};

  // Serial data reaches only the granted strip while a frame is being shifted.
  always_comb begin
    led_out = '0;
    if (state == START || state == RUN) led_out[grant] = bit_code_in;
  end

endmodule

// File: tb/tb_ws281x_frame_sched.sv
// Directed self-checking bench for ws281x_frame_sched, using shortened frame/gap/watchdog lengths.
module tb_ws281x_frame_sched;

  localparam int unsigned N    = 4;
  localparam int unsigned BPF  = 40;
  localparam int unsigned RSTC = 50;
  localparam int unsigned WDC  = 20;
  localparam int          LIM  = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       bit_done = 1'b0;
  logic       bit_code = 1'b0;
  logic [5:0] rd_addr = '0;
  logic       ctrl_start;
  logic [7:0] ram_addr;
  logic [3:0] led;
  logic [1:0] grant;
  logic       busy;
  logic [3:0] done;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;

  ws281x_frame_sched #(
    .N_CH(N), .BITS_PER_FRAME(BPF), .RST_CYCLES(RSTC), .WDOG_CYCLES(WDC)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .bit_done_in(bit_done),
    .bit_code_in(bit_code), .rd_addr_in(rd_addr), .ctrl_start_out(ctrl_start),
    .ram_rd_addr_out(ram_addr), .led_out(led), .grant_ch_out(grant),
    .busy_out(busy), .done_out(done), .err_out(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no end of test, want completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_req(input logic [3:0] m);
    req = m;
    tick();
    req = '0;
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    while (ctrl_start !== 1'b1 && cyc < LIM) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_done(output int cyc, output logic [3:0] d);
    cyc = 0;
    while (done === 4'b0000 && cyc < LIM) begin
      tick();
      cyc++;
    end
    d = done;
  endtask

  // Sends n bit_done pulses; optionally injects request mask rq alongside bit rq_at.
  task automatic send_bits(input int n, input logic [3:0] rq, input int rq_at,
                           output logic [3:0] l1, output logic [3:0] l0);
    l1 = '0;
    l0 = '0;
    for (int k = 0; k < n; k++) begin
      bit_code = ((k % 3) == 1);
      bit_done = 1'b1;
      if (k == rq_at) req = rq;
      #1;
      if (bit_code) l1 = l1 | led;
      else          l0 = l0 | led;
      tick();
      bit_done = 1'b0;
      req      = '0;
      if (k != n - 1) tick();
    end
    bit_code = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({ctrl_start, busy, err, done, led, grant} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 000", {ctrl_start, busy, err, done, led, grant});
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({ctrl_start, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got %b, want 00", {ctrl_start, busy});
    end
  endtask

  task automatic test_single();
    int c;
    logic [3:0] l1, l0, d;
    pulse_req(4'b0001);
    n_chk++;
    if (ctrl_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_start_early: got %b, want 0", ctrl_start);
    end
    tick();
    n_chk++;
    if ({ctrl_start, busy, grant} !== 4'b1100) begin
      n_fail++;
      $display("FAIL single_start: got %b, want 1100", {ctrl_start, busy, grant});
    end
    tick();
    n_chk++;
    if (ctrl_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_start_len: got %b, want 0", ctrl_start);
    end
    rd_addr = 6'h15;
    #1;
    n_chk++;
    if (ram_addr !== 8'h15) begin
      n_fail++;
      $display("FAIL single_addr: got %h, want 15", ram_addr);
    end
    send_bits(BPF, 4'b0000, -1, l1, l0);
    n_chk++;
    if ({l1, l0} !== 8'h10) begin
      n_fail++;
      $display("FAIL single_led: got %h, want 10", {l1, l0});
    end
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_gap_busy: got %b, want 1", busy);
    end
    wait_done(c, d);
    n_chk++;
    if (c !== RSTC || d !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_done: got cycles=%0d done=%b, want cycles=%0d done=0001", c, d, RSTC);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_end: got %b, want 0", busy);
    end
    tick();
    n_chk++;
    if (done !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_done_len: got %b, want 0000", done);
    end
  endtask

  task automatic test_simultaneous();
    int c;
    logic [3:0] l1, l0, d;
    pulse_req(4'b1010);
    wait_start(c);
    n_chk++;
    if (c !== 1 || grant !== 2'd1) begin
      n_fail++;
      $display("FAIL simul_first: got cycles=%0d grant=%0d, want cycles=1 grant=1", c, grant);
    end
    tick();
    rd_addr = 6'h3f;
    #1;
    n_chk++;
    if (ram_addr !== 8'h7f) begin
      n_fail++;
      $display("FAIL simul_addr1: got %h, want 7f", ram_addr);
    end
    send_bits(BPF, 4'b0000, -1, l1, l0);
    n_chk++;
    if ({l1, l0} !== 8'h20) begin
      n_fail++;
      $display("FAIL simul_led1: got %h, want 20", {l1, l0});
    end
    wait_done(c, d);
    n_chk++;
    if (c !== RSTC || d !== 4'b0010) begin
      n_fail++;
      $display("FAIL simul_done1: got cycles=%0d done=%b, want cycles=%0d done=0010", c, d, RSTC);
    end
    wait_start(c);
    n_chk++;
    if (c !== 1 || grant !== 2'd3) begin
      n_fail++;
      $display("FAIL simul_second: got cycles=%0d grant=%0d, want cycles=1 grant=3", c, grant);
    end
    tick();
    rd_addr = 6'h00;
    #1;
    n_chk++;
    if (ram_addr !== 8'hc0) begin
      n_fail++;
      $display("FAIL simul_addr3: got %h, want c0", ram_addr);
    end
    send_bits(BPF, 4'b0000, -1, l1, l0);
    wait_done(c, d);
    n_chk++;
    if ({l1, l0, d} !== 12'h808) begin
      n_fail++;
      $display("FAIL simul_led_done3: got %h, want 808", {l1, l0, d});
    end
  endtask

  task automatic test_fairness();
    int c;
    int e;
    logic [3:0] l1, l0, d, em;
    pulse_req(4'b0101);
    for (int f = 0; f < 4; f++) begin
      e  = (f % 2 == 0) ? 0 : 2;
      em = 4'(1 << e);
      wait_start(c);
      n_chk++;
      if (c !== 1 || 32'(grant) !== e) begin
        n_fail++;
        $display("FAIL fair_grant[%0d]: got cycles=%0d grant=%0d, want cycles=1 grant=%0d", f, c, grant, e);
      end
      tick();
      send_bits(BPF, (f < 2) ? em : 4'b0000, 3, l1, l0);
      wait_done(c, d);
      n_chk++;
      if (d !== em || l1 !== em) begin
        n_fail++;
        $display("FAIL fair_done[%0d]: got done=%b led=%b, want %b", f, d, l1, em);
      end
    end
    tick();
    tick();
    n_chk++;
    if ({ctrl_start, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL fair_drained: got %b, want 00", {ctrl_start, busy});
    end
  endtask

  task automatic test_requeue();
    int c;
    logic [3:0] l1, l0, d;
    pulse_req(4'b0010);
    wait_start(c);
    tick();
    send_bits(BPF, 4'b0010, 5, l1, l0);
    wait_done(c, d);
    n_chk++;
    if (d !== 4'b0010) begin
      n_fail++;
      $display("FAIL requeue_done1: got %b, want 0010", d);
    end
    wait_start(c);
    n_chk++;
    if (c !== 1 || grant !== 2'd1) begin
      n_fail++;
      $display("FAIL requeue_restart: got cycles=%0d grant=%0d, want cycles=1 grant=1", c, grant);
    end
    tick();
    send_bits(BPF, 4'b0000, -1, l1, l0);
    wait_done(c, d);
    n_chk++;
    if (c !== RSTC || d !== 4'b0010) begin
      n_fail++;
      $display("FAIL requeue_done2: got cycles=%0d done=%b, want cycles=%0d done=0010", c, d, RSTC);
    end
  endtask

  task automatic test_watchdog();
    int c;
    logic [3:0] l1, l0, d, dor;
    pulse_req(4'b0100);
    wait_start(c);
    n_chk++;
    if (grant !== 2'd2) begin
      n_fail++;
      $display("FAIL wdog_grant: got %0d, want 2", grant);
    end
    tick();
    send_bits(5, 4'b0001, 2, l1, l0);
    c = 0;
    while (err !== 1'b1 && c < LIM) begin
      tick();
      c++;
    end
    n_chk++;
    if (c !== WDC) begin
      n_fail++;
      $display("FAIL wdog_err_time: got %0d, want %0d", c, WDC);
    end
    tick();
    n_chk++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_err_len: got err=%b busy=%b, want err=0 busy=1", err, busy);
    end
    c   = 0;
    dor = done;
    while (busy === 1'b1 && c < LIM) begin
      tick();
      c++;
      dor = dor | done;
    end
    n_chk++;
    if (c !== RSTC - 1 || dor !== 4'b0000) begin
      n_fail++;
      $display("FAIL wdog_gap: got cycles=%0d done=%b, want cycles=%0d done=0000", c, dor, RSTC - 1);
    end
    wait_start(c);
    n_chk++;
    if (c !== 1 || grant !== 2'd0) begin
      n_fail++;
      $display("FAIL wdog_next: got cycles=%0d grant=%0d, want cycles=1 grant=0", c, grant);
    end
    tick();
    send_bits(BPF, 4'b0000, -1, l1, l0);
    wait_done(c, d);
    n_chk++;
    if (d !== 4'b0001) begin
      n_fail++;
      $display("FAIL wdog_next_done: got %b, want 0001", d);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    logic [3:0] l1, l0, d;
    pulse_req(4'b0010);
    wait_start(c);
    tick();
    send_bits(10, 4'b0100, 3, l1, l0);
    bit_code = 1'b1;
    rst_n    = 1'b0;
    #1;
    n_chk++;
    if ({ctrl_start, busy, err, done, led, grant, ram_addr[7:6]} !== 14'h0000) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %h, want 0000", {ctrl_start, busy, err, done, led, grant, ram_addr[7:6]});
    end
    bit_code = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    n_chk++;
    if ({ctrl_start, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_pending_lost: got %b, want 00", {ctrl_start, busy});
    end
    pulse_req(4'b1000);
    wait_start(c);
    n_chk++;
    if (c !== 1 || grant !== 2'd3) begin
      n_fail++;
      $display("FAIL rstmid_new_grant: got cycles=%0d grant=%0d, want cycles=1 grant=3", c, grant);
    end
    tick();
    send_bits(BPF, 4'b0000, -1, l1, l0);
    wait_done(c, d);
    n_chk++;
    if (c !== RSTC || d !== 4'b1000 || l1 !== 4'b1000) begin
      n_fail++;
      $display("FAIL rstmid_new_done: got cycles=%0d done=%b led=%b, want cycles=%0d done=1000 led=1000", c, d, l1, RSTC);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_requeue();
    test_watchdog();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
